// File: rtl/hps_io_initiator.sv
// FPGA-side initiator for the HPS I/O word-transfer bus: frames stream words
// under one select line, runs the io_clk/io_ack level handshake, returns io_dout.
module hps_io_initiator #(
    parameter int unsigned TIMEOUT = 65535,
    parameter int unsigned SETUP   = 1,
    parameter int unsigned GAP     = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_sel,
    input  logic        cmd_last,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_timeout,
    output logic        frame_open,
    output logic [15:0] io_din,
    output logic        io_clk,
    output logic        io_uio,
    output logic        io_osd,
    output logic        io_fpga,
    input  logic        io_ack,
    input  logic [15:0] io_dout,
    input  logic        io_wide
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_GAP     = 3'd4,
        ST_DROP    = 3'd5
    } state_t;

    localparam logic [15:0] SETUP_LAST = 16'(SETUP - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP - 1);
    localparam logic [16:0] TIMEOUT_L  = 17'(TIMEOUT);

    // An 8-bit responder only ever sees or returns the low byte.
    function automatic logic [15:0] narrow(input logic [15:0] word, input logic wide);
        logic [15:0] res;
        if (wide) begin
            res = word;
        end else begin
            res = {8'h00, word[7:0]};
        end
        return res;
    endfunction

    state_t      state_r, state_nxt;
    logic [15:0] cnt_r, cnt_nxt;
    logic        last_r, last_nxt;
    logic        ack_meta_r, ack_sync_r;
    logic        cmd_ready_nxt, rsp_valid_nxt, rsp_timeout_nxt, frame_open_nxt;
    logic [15:0] rsp_data_nxt, io_din_nxt;
    logic        io_clk_nxt, io_uio_nxt, io_osd_nxt, io_fpga_nxt;
    logic        accept_s, wait_hit_s;

    assign accept_s   = cmd_valid & cmd_ready;
    assign wait_hit_s = (({1'b0, cnt_r} + 17'd1) == TIMEOUT_L);

    // Two-flop synchroniser for the asynchronous responder acknowledge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ack_meta_r <= 1'b0;
            ack_sync_r <= 1'b0;
        end else begin
            ack_meta_r <= io_ack;
            ack_sync_r <= ack_meta_r;
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 16'd0;
            last_r      <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 16'd0;
            rsp_timeout <= 1'b0;
            frame_open  <= 1'b0;
            io_din      <= 16'd0;
            io_clk      <= 1'b0;
            io_uio      <= 1'b0;
            io_osd      <= 1'b0;
            io_fpga     <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            cnt_r       <= cnt_nxt;
            last_r      <= last_nxt;
            cmd_ready   <= cmd_ready_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_data    <= rsp_data_nxt;
            rsp_timeout <= rsp_timeout_nxt;
            frame_open  <= frame_open_nxt;
            io_din      <= io_din_nxt;
            io_clk      <= io_clk_nxt;
            io_uio      <= io_uio_nxt;
            io_osd      <= io_osd_nxt;
            io_fpga     <= io_fpga_nxt;
        end
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_nxt       = state_r;
        cnt_nxt         = cnt_r;
        last_nxt        = last_r;
        cmd_ready_nxt   = 1'b0;
        rsp_valid_nxt   = 1'b0;
        rsp_timeout_nxt = 1'b0;
        rsp_data_nxt    = rsp_data;
        frame_open_nxt  = frame_open;
        io_din_nxt      = io_din;
        io_clk_nxt      = io_clk;
        io_uio_nxt      = io_uio;
        io_osd_nxt      = io_osd;
        io_fpga_nxt     = io_fpga;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    last_nxt = cmd_last;
                    cnt_nxt  = 16'd0;
                    if (frame_open) begin
                        io_din_nxt = narrow(cmd_data, io_wide);
                        state_nxt  = ST_SETUP;
                    end else if (cmd_sel == 2'd0) begin
                        state_nxt = ST_DROP;
                    end else begin
                        io_din_nxt     = narrow(cmd_data, io_wide);
                        frame_open_nxt = 1'b1;
                        state_nxt      = ST_SETUP;
                        case (cmd_sel)
                            2'd1:    io_uio_nxt  = 1'b1;
                            2'd2:    io_osd_nxt  = 1'b1;
                            2'd3:    io_fpga_nxt = 1'b1;
                            default: io_uio_nxt  = 1'b0;
                        endcase
                    end
                end else begin
                    cmd_ready_nxt = 1'b1;
                end
            end

            ST_SETUP: begin
                if (cnt_r == SETUP_LAST) begin
                    io_clk_nxt = 1'b1;
                    cnt_nxt    = 16'd0;
                    state_nxt  = ST_STROBE;
                end else begin
                    cnt_nxt = cnt_r + 16'd1;
                end
            end

            ST_STROBE: begin
                if (ack_sync_r) begin
                    rsp_data_nxt = narrow(io_dout, io_wide);
                    io_clk_nxt   = 1'b0;
                    cnt_nxt      = 16'd0;
                    state_nxt    = ST_RELEASE;
                end else if (wait_hit_s) begin
                    io_clk_nxt      = 1'b0;
                    io_uio_nxt      = 1'b0;
                    io_osd_nxt      = 1'b0;
                    io_fpga_nxt     = 1'b0;
                    frame_open_nxt  = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_timeout_nxt = 1'b1;
                    rsp_data_nxt    = 16'd0;
                    cnt_nxt         = 16'd0;
                    state_nxt       = ST_GAP;
                end else begin
                    cnt_nxt = cnt_r + 16'd1;
                end
            end

            ST_RELEASE: begin
                if (!ack_sync_r) begin
                    rsp_valid_nxt = 1'b1;
                    cnt_nxt       = 16'd0;
                    if (last_r) begin
                        io_uio_nxt     = 1'b0;
                        io_osd_nxt     = 1'b0;
                        io_fpga_nxt    = 1'b0;
                        frame_open_nxt = 1'b0;
                        state_nxt      = ST_GAP;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (wait_hit_s) begin
                    io_clk_nxt      = 1'b0;
                    io_uio_nxt      = 1'b0;
                    io_osd_nxt      = 1'b0;
                    io_fpga_nxt     = 1'b0;
                    frame_open_nxt  = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_timeout_nxt = 1'b1;
                    rsp_data_nxt    = 16'd0;
                    cnt_nxt         = 16'd0;
                    state_nxt       = ST_GAP;
                end else begin
                    cnt_nxt = cnt_r + 16'd1;
                end
            end

            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_nxt   = 16'd0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt_r + 16'd1;
                end
            end

            // Illegal select on frame open: the word is consumed and refused.
            ST_DROP: begin
                rsp_valid_nxt   = 1'b1;
                rsp_timeout_nxt = 1'b1;
                rsp_data_nxt    = 16'd0;
                state_nxt       = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    hps_io_initiator_chk u_chk (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .io_uio      (io_uio),
        .io_osd      (io_osd),
        .io_fpga     (io_fpga),
        .io_clk      (io_clk),
        .frame_open  (frame_open),
        .rsp_valid   (rsp_valid),
        .rsp_timeout (rsp_timeout)
    );

endmodule

// Protocol invariants of the initiator's bus outputs.
module hps_io_initiator_chk (
    input logic clk_sys,
    input logic reset,
    input logic io_uio,
    input logic io_osd,
    input logic io_fpga,
    input logic io_clk,
    input logic frame_open,
    input logic rsp_valid,
    input logic rsp_timeout
);

    a_sel_onehot: assert property (@(posedge clk_sys) disable iff (reset)
        $onehot0({io_uio, io_osd, io_fpga}));

    a_clk_in_frame: assert property (@(posedge clk_sys) disable iff (reset)
        io_clk |-> frame_open);

    a_timeout_qualified: assert property (@(posedge clk_sys) disable iff (reset)
        rsp_timeout |-> rsp_valid);

endmodule
